// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN result path: pixel width, pooling FSM states, signed max.
package cnn_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } pool_state_t;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_max2.sv
// Signed max of two operands.
// Combinational, no latency; no flow control.
module cnn_max2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/cnn_maxpool.sv
// 2x2/stride-2 signed max-pool over a row-major pixel stream; CNN_MAXPOOL_RELU_EN clamps negatives first.
// Latency: pooled value registered 1 cycle after the accepted odd-row, odd-col pixel.
// No backpressure: every in_valid pixel is consumed, gaps freeze all state.
module cnn_maxpool
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int FMAP_W = 4,
  parameter int FMAP_H = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  localparam int CW = $clog2(FMAP_W);
  localparam int RW = $clog2(FMAP_H);
  localparam int NB = FMAP_W / 2;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  pool_state_t       state_q, state_d;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic [DATA_W-1:0] px;
  logic [DATA_W-1:0] h_reg;
  logic [DATA_W-1:0] h_max;
  logic [DATA_W-1:0] v_max;
  logic [DATA_W-1:0] row_buf [NB];
  logic [IW-1:0]     buf_idx;
  logic              last_col, last_row;
  logic              odd_row, buf_wr, pool_fire, pool_last;

`ifdef CNN_MAXPOOL_RELU_EN
  assign px = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign px = in_data;
`endif

  assign last_col = (col_cnt == CW'(FMAP_W - 1));
  assign last_row = (row_cnt == RW'(FMAP_H - 1));
  assign buf_idx  = IW'(col_cnt >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EVEN;
      ST_EVEN: if (in_valid && last_col) state_d = ST_ODD;
      ST_ODD:  if (in_valid && last_col) state_d = last_row ? ST_IDLE : ST_EVEN;
      default: state_d = ST_IDLE;
    endcase
  end

  // IDLE behaves as an even row: its pixel is row 0, col 0 and counters already sit at zero.
  always_comb begin
    odd_row   = (state_q == ST_ODD);
    buf_wr    = in_valid && !odd_row && col_cnt[0];
    pool_fire = in_valid && odd_row && col_cnt[0];
    pool_last = pool_fire && last_col && last_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  cnn_max2 #(.W(DATA_W)) u_hmax (
    .a (h_reg),
    .b (px),
    .y (h_max)
  );

  cnn_max2 #(.W(DATA_W)) u_vmax (
    .a (row_buf[buf_idx]),
    .b (h_max),
    .y (v_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg <= '0;
      for (int i = 0; i < NB; i++) row_buf[i] <= '0;
    end else begin
      if (in_valid && !col_cnt[0]) h_reg <= px;
      if (buf_wr) row_buf[buf_idx] <= h_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= pool_fire;
      out_data   <= pool_fire ? v_max : '0;
      frame_done <= pool_last;
    end
  end

endmodule

// File: tb/tb_cnn_maxpool.sv
// Directed bench for cnn_maxpool with the default 4x4 map and 16-bit pixels.
module tb_cnn_maxpool;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic        [DW-1:0] out_data;
  logic                 frame_done;

  cnn_maxpool dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [DW-1:0] frame_px [16];
  logic signed [DW-1:0] exp4     [4];
  logic                 got_vld  [16];
  logic                 got_fd   [16];
  logic        [DW-1:0] got_dat  [16];
  int                   gap_bad;

  function automatic int pool_slot(input int i);
    case (i)
      5:       return 0;
      7:       return 1;
      13:      return 2;
      15:      return 3;
      default: return -1;
    endcase
  endfunction

  // {out_valid, frame_done, out_data} expected right after pixel i is accepted
  function automatic logic [DW+1:0] exp_word(input int i);
    int s;
    s = pool_slot(i);
    if (s < 0) return {1'b0, 1'b0, {DW{1'b0}}};
    return {1'b1, (i == 15), exp4[s]};
  endfunction

  function automatic logic [DW+1:0] got_word(input int i);
    return {got_vld[i], got_fd[i], got_dat[i]};
  endfunction

  // Drives frame_px with 0..max_gap idle cycles before each pixel; starts and ends on a negedge.
  task automatic run_frame(input int max_gap);
    int g;
    gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        if (out_valid !== 1'b0 || out_data !== '0 || frame_done !== 1'b0) gap_bad++;
      end
      in_valid = 1'b1;
      in_data  = frame_px[i];
      @(negedge clk);
      in_valid   = 1'b0;
      in_data    = '0;
      got_vld[i] = out_valid;
      got_fd[i]  = frame_done;
      got_dat[i] = out_data;
    end
  endtask

  task automatic load_ramp(input bit down);
    for (int i = 0; i < 16; i++) frame_px[i] = down ? DW'(16 - i) : DW'(i + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_data !== '0) begin n_err++; $display("FAIL reset out_data got %0d want 0", out_data); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset frame_done got %b want 0", frame_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_ramp(1'b0);
    exp4[0] = 16'sd6; exp4[1] = 16'sd8; exp4[2] = 16'sd14; exp4[3] = 16'sd16;
    run_frame(0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL basic px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
  endtask

  task automatic test_all_neg();
    for (int i = 0; i < 16; i++) frame_px[i] = -16'sd5;
`ifdef CNN_MAXPOOL_RELU_EN
    for (int k = 0; k < 4; k++) exp4[k] = 16'sd0;
`else
    for (int k = 0; k < 4; k++) exp4[k] = -16'sd5;
`endif
    run_frame(0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL all_neg px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
  endtask

  task automatic test_gaps();
    load_ramp(1'b0);
    exp4[0] = 16'sd6; exp4[1] = 16'sd8; exp4[2] = 16'sd14; exp4[3] = 16'sd16;
    run_frame(3);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL gaps px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
    n_cmp++;
    if (gap_bad !== 0) begin n_err++; $display("FAIL gaps idle_outputs got %0d want 0", gap_bad); end
  endtask

  task automatic test_back_to_back();
    load_ramp(1'b0);
    exp4[0] = 16'sd6; exp4[1] = 16'sd8; exp4[2] = 16'sd14; exp4[3] = 16'sd16;
    run_frame(0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL b2b_a px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
    load_ramp(1'b1);
    exp4[0] = 16'sd16; exp4[1] = 16'sd14; exp4[2] = 16'sd8; exp4[3] = 16'sd6;
    run_frame(0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL b2b_b px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 1);
      @(negedge clk);
      if (i == 7) begin
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, 16'd8}) begin
          n_err++;
          $display("FAIL midrst pre_px8 got vld=%b dat=%0d want vld=1 dat=8", out_valid, out_data);
        end
      end
    end
    // pixels offered while reset is held must not be consumed
    in_data = 16'sd100;
    rst_n   = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, frame_done, out_data} !== '0) begin
      n_err++;
      $display("FAIL midrst during got vld=%b fd=%b dat=%0d want 0", out_valid, frame_done, out_data);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, frame_done, out_data} !== '0) begin
      n_err++;
      $display("FAIL midrst held got vld=%b fd=%b dat=%0d want 0", out_valid, frame_done, out_data);
    end
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    @(negedge clk);
    load_ramp(1'b0);
    exp4[0] = 16'sd6; exp4[1] = 16'sd8; exp4[2] = 16'sd14; exp4[3] = 16'sd16;
    run_frame(0);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL midrst px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
  endtask

  task automatic test_mixed_signs();
    frame_px[0]  = 16'sh8000; frame_px[1]  = 16'sh7FFF; frame_px[2]  = -16'sd1;  frame_px[3]  = 16'sd0;
    frame_px[4]  = -16'sd2;   frame_px[5]  = -16'sd3;   frame_px[6]  = -16'sd4;  frame_px[7]  = -16'sd5;
    frame_px[8]  = -16'sd7;   frame_px[9]  = -16'sd8;   frame_px[10] = -16'sd9;  frame_px[11] = -16'sd10;
    frame_px[12] = -16'sd11;  frame_px[13] = -16'sd12;  frame_px[14] = -16'sd13; frame_px[15] = -16'sd14;
    exp4[0] = 16'sh7FFF;
    exp4[1] = 16'sd0;
`ifdef CNN_MAXPOOL_RELU_EN
    exp4[2] = 16'sd0;
    exp4[3] = 16'sd0;
`else
    exp4[2] = -16'sd7;
    exp4[3] = -16'sd9;
`endif
    run_frame(1);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (got_word(i) !== exp_word(i)) begin
        n_err++;
        $display("FAIL mixed px%0d got %h want %h", i + 1, got_word(i), exp_word(i));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_all_neg();
    test_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    test_mixed_signs();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
